// File: rtl/tmds_align_if.sv
// rtl/tmds_align_if.sv - TMDS lane word-alignment bus between deserializer and alignment controller
interface tmds_align_if;
    logic [9:0] i_word;
    logic       o_bitslip;
    logic       o_aligned;
    logic [3:0] o_slip_phase;
    logic [7:0] o_relock_cnt;

    modport master (
        output i_word,
        input  o_bitslip,
        input  o_aligned,
        input  o_slip_phase,
        input  o_relock_cnt
    );

    modport slave (
        input  i_word,
        output o_bitslip,
        output o_aligned,
        output o_slip_phase,
        output o_relock_cnt
    );
endinterface

// File: rtl/tmds_align_ctrl.sv
// rtl/tmds_align_ctrl.sv - TMDS lane bitslip/lock controller; optional lock-loss counter via TMDS_ALIGN_STATS_EN
module tmds_align_ctrl #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16,
    parameter int LOCK_TIMEOUT   = 8192
) (
    input  logic          i_pixclk,
    input  logic          i_rst_n,
    tmds_align_if.slave   bus
);
    localparam int T_MAX0 = (SEARCH_TIMEOUT > SLIP_WAIT) ? SEARCH_TIMEOUT : SLIP_WAIT;
    localparam int T_MAX  = (T_MAX0 > LOCK_TIMEOUT) ? T_MAX0 : LOCK_TIMEOUT;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int RW     = $clog2(CTRL_RUN + 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [RW-1:0] run, run_next, run_inc;
    logic [3:0]    phase_q, phase_next;
    logic          bitslip_q, aligned_q;
    logic          is_token, hit;

    always_comb begin
        is_token = 1'b0;
        case (bus.i_word)
            10'b1101010100,
            10'b0010101011,
            10'b0101010100,
            10'b1010101011: is_token = 1'b1;
            default:        is_token = 1'b0;
        endcase
    end

    always_comb begin
        run_inc = '0;
        if (is_token)
            run_inc = (run == RW'(CTRL_RUN)) ? run : run + 1'b1;
        hit = is_token && (run == RW'(CTRL_RUN - 1));
    end

    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        run_next   = run;
        phase_next = phase_q;
        case (state)
            ST_SEARCH: begin
                run_next = run_inc;
                if (hit)
                    state_next = ST_LOCKED;
                else if (timer == TW'(SEARCH_TIMEOUT - 1))
                    state_next = ST_SLIP;
            end
            ST_SLIP: begin
                run_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                run_next = '0;
                if (timer == TW'(SLIP_WAIT - 1))
                    state_next = ST_SEARCH;
            end
            ST_LOCKED: begin
                run_next = run_inc;
                if (hit)
                    timer_next = '0;
                else if (timer == TW'(LOCK_TIMEOUT - 1))
                    state_next = ST_SEARCH;
            end
            default: state_next = ST_SEARCH;
        endcase
        // A hit restarts the run so a long blanking period keeps producing hits
        if (hit && (state == ST_SEARCH || state == ST_LOCKED))
            run_next = '0;
        if (state_next != state)
            timer_next = '0;
        if (state_next == ST_SLIP)
            phase_next = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_SEARCH;
            timer     <= '0;
            run       <= '0;
            phase_q   <= 4'd0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            run       <= run_next;
            phase_q   <= phase_next;
            bitslip_q <= (state_next == ST_SLIP);
            aligned_q <= (state_next == ST_LOCKED);
        end
    end

`ifdef TMDS_ALIGN_STATS_EN
    logic [7:0] relock_q;

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n)
            relock_q <= 8'h00;
        else if (state == ST_LOCKED && state_next == ST_SEARCH && relock_q != 8'hFF)
            relock_q <= relock_q + 8'h01;
    end

    assign bus.o_relock_cnt = relock_q;
`else
    assign bus.o_relock_cnt = 8'h00;
`endif

    assign bus.o_bitslip    = bitslip_q;
    assign bus.o_aligned    = aligned_q;
    assign bus.o_slip_phase = phase_q;
endmodule

// File: tb/tb_tmds_align_ctrl.sv
// tb/tb_tmds_align_ctrl.sv - directed self-checking bench for tmds_align_ctrl
module tb_tmds_align_ctrl;
    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;
    localparam logic [9:0] D  = 10'b0000011111;
`ifdef TMDS_ALIGN_STATS_EN
    localparam int RELOCK_ONE = 1;
    localparam int RELOCK_SAT = 255;
`else
    localparam int RELOCK_ONE = 0;
    localparam int RELOCK_SAT = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    tmds_align_if bus ();

    tmds_align_ctrl #(
        .CTRL_RUN       (4),
        .SEARCH_TIMEOUT (32),
        .SLIP_WAIT      (4),
        .LOCK_TIMEOUT   (64)
    ) dut (
        .i_pixclk (clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [9:0] w);
        @(negedge clk);
        bus.i_word = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_word = D;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int seen_slip;
        int seen_drop;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.i_word = D;

        // reset state and basic lock
        do_reset();
        check("rst_bitslip", bus.o_bitslip, 0);
        check("rst_aligned", bus.o_aligned, 0);
        check("rst_phase", bus.o_slip_phase, 0);
        check("rst_relock", bus.o_relock_cnt, 0);
        seen_slip = 0;
        repeat (3) begin
            tick(T0);
            seen_slip += bus.o_bitslip;
        end
        check("lock_3tok_aligned", bus.o_aligned, 0);
        tick(T0);
        seen_slip += bus.o_bitslip;
        check("lock_4tok_aligned", bus.o_aligned, 1);
        check("lock_no_slip", seen_slip, 0);
        check("lock_phase", bus.o_slip_phase, 0);

        // slips with no tokens
        do_reset();
        seen_slip = 0;
        repeat (31) begin
            tick(D);
            seen_slip += bus.o_bitslip;
        end
        check("pre_slip_quiet", seen_slip, 0);
        tick(D);
        check("slip1_pulse", bus.o_bitslip, 1);
        check("slip1_phase", bus.o_slip_phase, 1);
        for (int k = 2; k <= 10; k++) begin
            seen_slip = 0;
            repeat (36) begin
                tick(D);
                seen_slip += bus.o_bitslip;
            end
            check($sformatf("slip%0d_gap", k), seen_slip, 0);
            tick(D);
            check($sformatf("slip%0d_pulse", k), bus.o_bitslip, 1);
            check($sformatf("slip%0d_phase", k), bus.o_slip_phase, k % 10);
        end

        // broken run does not lock; mixed tokens do
        do_reset();
        repeat (3) tick(T1);
        tick(D);
        repeat (3) tick(T2);
        check("broken_run_aligned", bus.o_aligned, 0);
        tick(T3);
        check("mixed_run_aligned", bus.o_aligned, 1);

        // hit coincident with search timeout
        do_reset();
        repeat (28) tick(D);
        seen_slip = 0;
        tick(T0); seen_slip += bus.o_bitslip;
        tick(T1); seen_slip += bus.o_bitslip;
        tick(T2); seen_slip += bus.o_bitslip;
        check("tmo_hit_pre_aligned", bus.o_aligned, 0);
        tick(T3); seen_slip += bus.o_bitslip;
        check("tmo_hit_aligned", bus.o_aligned, 1);
        check("tmo_hit_no_slip", seen_slip, 0);
        check("tmo_hit_phase", bus.o_slip_phase, 0);

        // lock loss and relock
        seen_slip = 0;
        seen_drop = 0;
        repeat (63) begin
            tick(D);
            seen_slip += bus.o_bitslip;
            seen_drop += (bus.o_aligned == 1'b0) ? 1 : 0;
        end
        check("loss_hold_aligned", seen_drop, 0);
        tick(D);
        seen_slip += bus.o_bitslip;
        check("loss_aligned", bus.o_aligned, 0);
        check("loss_no_slip", seen_slip, 0);
        repeat (4) tick(T0);
        check("relock_aligned", bus.o_aligned, 1);
        check("relock_cnt", bus.o_relock_cnt, RELOCK_ONE);

        // async reset while locked
        #2;
        rst_n = 1'b0;
        #1;
        check("async_lock_aligned", bus.o_aligned, 0);
        check("async_lock_relock", bus.o_relock_cnt, 0);
        do_reset();

        // async reset during bitslip pulse
        repeat (32) tick(D);
        check("async_pre_pulse", bus.o_bitslip, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bitslip", bus.o_bitslip, 0);
        check("async_aligned", bus.o_aligned, 0);
        check("async_phase", bus.o_slip_phase, 0);
        do_reset();
        seen_slip = 0;
        repeat (31) begin
            tick(D);
            seen_slip += bus.o_bitslip;
        end
        check("restart_quiet", seen_slip, 0);
        tick(D);
        check("restart_slip", bus.o_bitslip, 1);
        check("restart_phase", bus.o_slip_phase, 1);

        // relock counter saturation
        do_reset();
        for (int c = 0; c < 300; c++) begin
            repeat (4) tick(T0);
            repeat (64) tick(D);
        end
        check("sat_aligned", bus.o_aligned, 0);
        check("sat_relock", bus.o_relock_cnt, RELOCK_SAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
